// File: rtl/alu_muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// alu_muldiv_sequencer
//
// Multi-cycle unsigned 32x32 multiply (MULTU) and 32/32 divide (DIVU).
// The block borrows the shared single-cycle ALU for 32 iterations: shift-add
// for multiply and restoring shift-subtract for divide. The 64-bit result is
// left in hi/lo.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-high reset
//   start        in   request; accepted only in IDLE or DONE
//   op           in   0 = MULTU, 1 = DIVU (captured with start)
//   opa          in   multiplicand / dividend (captured with start)
//   opb          in   multiplier / divisor (captured with start)
//   busy         out  high while iterating
//   done         out  one-cycle pulse, hi/lo valid
//   hi           out  MULTU product[63:32] / DIVU remainder
//   lo           out  MULTU product[31:0]  / DIVU quotient
//   alu_src1     out  ALU Src1
//   alu_src2     out  ALU Src2
//   alu_control  out  ALU ALUControl
//   alu_result   in   ALU result, combinational in the same cycle
//
// State   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no operation in flight, ALU inputs parked at idle values
// RUN     | one multiply/divide step per cycle, cnt = step index
// DONE    | result valid for one cycle; start here chains a new op
// ---------------------------------------------------------------------------
module alu_muldiv_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] alu_src1,
    output logic [31:0] alu_src2,
    output logic [3:0]  alu_control,
    input  logic [31:0] alu_result
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    logic [1:0]  state;
    logic [4:0]  cnt;
    logic [31:0] divisor_or_mcand;
    logic        op_q;

    logic [31:0] div_r;
    logic        div_b;
    logic        div_take;
    logic        mul_carry;

    // Divide: the partial remainder shifted left one bit, with the bit that
    // fell out of hi kept separately so the compare covers 33 bits.
    assign div_r = {hi[30:0], lo[31]};
    assign div_b = hi[31];

    assign div_take  = div_b | (div_r >= divisor_or_mcand);
    // The 32-bit add overflowed exactly when the sum wrapped below hi.
    assign mul_carry = (alu_result < hi);

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

    always_comb begin
        alu_src1    = 32'd0;
        alu_src2    = 32'd0;
        alu_control = ALU_ADD;
        if (state == ST_RUN) begin
            if (op_q) begin
                alu_control = ALU_SUB;
                alu_src1    = div_r;
                alu_src2    = divisor_or_mcand;
            end else begin
                alu_control = ALU_ADD;
                alu_src1    = hi;
                alu_src2    = lo[0] ? divisor_or_mcand : 32'd0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= ST_IDLE;
            cnt              <= 5'd0;
            hi               <= 32'd0;
            lo               <= 32'd0;
            divisor_or_mcand <= 32'd0;
            op_q             <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        hi               <= 32'd0;
                        lo               <= opa;
                        divisor_or_mcand <= opb;
                        op_q             <= op;
                        cnt              <= 5'd0;
                        state            <= ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (op_q) begin
                        hi <= div_take ? alu_result : div_r;
                        lo <= {lo[30:0], div_take};
                    end else begin
                        // 65-bit {carry, sum, lo} shifted right by one.
                        hi <= {mul_carry, alu_result[31:1]};
                        lo <= {alu_result[0], lo[31:1]};
                    end
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state <= ST_DONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
module tb_alu_muldiv_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] alu_src1;
    logic [31:0] alu_src2;
    logic [3:0]  alu_control;
    logic [31:0] alu_result;

    // Reference ALU: ADD for 0010, SUB for 0110.
    assign alu_result = (alu_control == 4'b0110) ? (alu_src1 - alu_src2)
                                                 : (alu_src1 + alu_src2);

    alu_muldiv_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .opa        (opa),
        .opb        (opb),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo),
        .alu_src1   (alu_src1),
        .alu_src2   (alu_src2),
        .alu_control(alu_control),
        .alu_result (alu_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   busy_run = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse.
    always @(negedge clk) begin
        if (reset) begin
            busy_run = 0;
        end else begin
            checks++;
            if (busy && done) begin
                errors++;
                $display("FAIL busy_done_overlap: busy=%0b done=%0b at cycle %0d", busy, done, cyc);
            end
            if (busy) busy_run++;
            if (done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: done=1 at cycle %0d with no operation pending", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk({e.name, "_hi"}, hi, e.hi);
                    chk({e.name, "_lo"}, lo, e.lo);
                    chk({e.name, "_latency"}, cyc, e.cyc);
                    chk({e.name, "_busy_cycles"}, busy_run, 32);
                end
                busy_run = 0;
            end
        end
    end

    // Drive start for one cycle (from a negedge) and record the expectation.
    task automatic issue(input string name, input logic o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        exp_t e;
        start = 1'b1;
        op    = o;
        opa   = a;
        opb   = b;
        e.hi  = eh;
        e.lo  = el;
        e.cyc = cyc + 33;
        e.name = name;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: %0d results still pending after %0d cycles, expected 0", name, sb.size(), n);
            sb.delete();
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        opa   = 32'd0;
        opb   = 32'd0;
        #1;
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_done",  {31'd0, done}, 32'd0);
        chk("rst_hi",    hi, 32'd0);
        chk("rst_lo",    lo, 32'd0);
        chk("rst_src1",  alu_src1, 32'd0);
        chk("rst_src2",  alu_src2, 32'd0);
        chk("rst_ctrl",  {28'd0, alu_control}, 32'd2);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        issue("mul_7x6", 1'b0, 32'd7, 32'd6, 32'h0, 32'h2A);
        wait_drain("mul_7x6");
        @(negedge clk);
        chk("idle_ctrl", {28'd0, alu_control}, 32'd2);
        chk("idle_src1", alu_src1, 32'd0);
        chk("hold_lo",   lo, 32'h2A);

        issue("mul_max", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        wait_drain("mul_max");
        issue("div_100_7", 1'b1, 32'd100, 32'd7, 32'd2, 32'd14);
        wait_drain("div_100_7");
        issue("div_msb_3", 1'b1, 32'h80000000, 32'd3, 32'd2, 32'h2AAAAAAA);
        wait_drain("div_msb_3");
        issue("div_by_0", 1'b1, 32'h12345678, 32'd0, 32'h12345678, 32'hFFFFFFFF);
        wait_drain("div_by_0");

        // start pulsed mid-RUN must be ignored
        issue("mul_ign", 1'b0, 32'h00010000, 32'h00010000, 32'h1, 32'h0);
        repeat (9) @(negedge clk);
        start = 1'b1; op = 1'b0; opa = 32'd3; opb = 32'd5;
        @(negedge clk);
        start = 1'b0;
        wait_drain("mul_ign");
        repeat (3) @(negedge clk);

        // back-to-back: second start in the DONE cycle
        issue("div_b2b", 1'b1, 32'd1000, 32'd10, 32'd0, 32'd100);
        begin
            int n;
            n = 0;
            while (!done && n < 100) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (!done) begin
                errors++;
                $display("FAIL b2b_wait: done=%0b after %0d cycles, expected 1", done, n);
            end
        end
        issue("mul_b2b", 1'b0, 32'h12345678, 32'd16, 32'h1, 32'h23456780);
        wait_drain("mul_b2b");

        // reset in cycle 5 of RUN aborts the operation
        issue("mul_abort", 1'b0, 32'd9, 32'd9, 32'd0, 32'd81);
        repeat (4) @(negedge clk);
        chk("abort_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        sb.delete();
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_hi",   hi, 32'd0);
        chk("abort_lo",   lo, 32'd0);
        chk("abort_ctrl", {28'd0, alu_control}, 32'd2);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("abort_no_busy", {31'd0, busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
